if_inst_queue: RTL and testbench
================================

// Module: if_inst_queue
// PURPOSE
//  Instruction fetch queue between the fetch unit and the ID stage. Buffers fetched
//  {pc, inst} pairs in a circular FIFO and presents the head word to decode, which
//  feeds the immediate extender and the control decoder. Absorbs decode stalls
//  without re-fetching. Discards all buffered words on a redirect (branch, jump or trap).
// PARAMETERS
//  DEPTH  4             Number of entries. Must be a power of 2 and >= 2.
//  NOP    32'h00000013  Word driven on out_inst while the queue is empty (addi x0,x0,0).
// PORTS
//  clk        in   1      Clock. All state changes on the rising edge.
//  rst        in   1      Synchronous reset, active-high.
//  flush      in   1      Redirect. Discard every entry and any push in the same cycle.
//  in_valid   in   1      Fetch presents a word.
//  in_ready   out  1      Queue can accept a word. Equals (count != DEPTH).
//  in_inst    in   32     Fetched instruction.
//  in_pc      in   32     PC of in_inst.
//  out_valid  out  1      Head word is valid. Equals (count != 0).
//  out_ready  in   1      Decode consumes the head this cycle.
//  out_inst   out  32     Head instruction. Equals NOP when out_valid=0.
//  out_pc     out  32     Head PC. Equals 0 when out_valid=0.
//  count      out  clog2(DEPTH)+1  Current occupancy, 0..DEPTH.
// BEHAVIOUR
//  - Handshakes:
//    - push = in_valid & in_ready & ~flush.
//    - pop  = out_valid & out_ready & ~flush.
//  - Storage: wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrap modulo DEPTH. count is held
//    separately; full/empty are derived only from count.
//  - Push: writes {in_pc, in_inst} at wr_ptr, then wr_ptr+1.
//  - Pop: rd_ptr+1.
//  - count_next = count + push - pop.
//  - Output path: first-word fall-through from storage. No combinational in->out bypass.
//    A word pushed into an empty queue appears on out_* one cycle later (latency 1).
//  - Full: in_ready=0. A push and a pop in the same full cycle is not possible, because
//    in_ready is not qualified by out_ready. in_ready never depends combinationally on
//    out_ready, and out_valid never on in_valid.
//  - Empty: out_valid=0, out_inst=NOP, out_pc=0. out_ready is ignored.
//  - Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
//  - Flush (highest priority after rst): at the next edge wr_ptr=rd_ptr=0 and count=0, so
//    out_valid=0 the following cycle. in_ready stays at its current value during the
//    flush cycle. The word presented in that cycle is dropped, not stored. Storage
//    contents are not cleared.
//  - Reset: rst=1 at an edge forces wr_ptr=rd_ptr=0 and count=0 from the next cycle:
//    out_valid=0, out_inst=NOP, out_pc=0, in_ready=1, count=0. Reset mid-operation
//    discards all entries. rst overrides flush, push and pop.
//  - X-safety: out_inst and out_pc never expose unwritten storage, because they are
//    muxed to NOP/0 when empty.
// TESTING
//  1. Reset, then idle -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1, count=0.
//  2. Push {pc=0x0, inst=0x00500093} with out_ready=0 -> next cycle out_valid=1,
//     out_inst=0x00500093, out_pc=0x0, count=1.
//  3. Fill: push pc 0x0,0x4,0x8,0xC (DEPTH=4), out_ready=0 -> count=4, in_ready=0.
//     A 5th word (pc 0x10) held on in_valid is not taken. Pop once -> in_ready=1,
//     then pc 0x10 is accepted.
//  4. Wrap: stream 10 words with push and pop every cycle after the first push ->
//     count stays 1. out_pc follows 0x0,0x4,...,0x24 in order, with no loss or duplication.
//  5. Flush with count=3 while in_valid=1 (pc 0x40) -> next cycle count=0, out_valid=0.
//     pc 0x40 is never output. Next push, pc 0x80, is output first.
//  6. rst asserted with count=2 plus simultaneous push and pop -> next cycle count=0,
//     out_valid=0, in_ready=1. Subsequent traffic starts at pointer 0.

Source files
------------

// File: rtl/if_inst_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} pairs between fetch and decode.
// First-word fall-through from storage, redirect flush, NOP/0 on the outputs when empty.
module if_inst_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic push;
    logic pop;

    // Full/empty come only from the registered count, so neither handshake
    // side ever depends combinationally on the other side's inputs.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; the output mux hides stale or unwritten entries.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= in_inst;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

    always_comb begin
        out_inst = NOP;
        out_pc   = '0;
        if (out_valid) begin
            out_inst = inst_mem_q[rd_ptr_q];
            out_pc   = pc_mem_q[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed scoreboard bench for if_inst_queue: a queue model of the FIFO is
// updated from the stimulus, and every cycle the DUT outputs are checked against it.
module tb_if_inst_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard entries are {pc, inst}; the front is the word decode should see.
    logic [63:0] sbQueue [$];

    if_inst_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        int          n;
        logic [63:0] head;
        n    = sbQueue.size();
        head = (n != 0) ? sbQueue[0] : {32'h0, NOP};
        checkValue("out_valid", {31'b0, out_valid}, 32'(n != 0));
        checkValue("in_ready",  {31'b0, in_ready},  32'(n != DEPTH));
        checkValue("count",     {29'b0, count},     32'(n));
        checkValue("out_pc",    out_pc,             head[63:32]);
        checkValue("out_inst",  out_inst,           head[31:0]);
    endtask

    // One cycle: drive at the falling edge, check settled outputs, update the model.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy,
                                 input logic fl, input logic rs);
        int   n;
        logic doPush;
        logic doPop;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = $urandom;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        #1;
        checkOutput();
        n      = sbQueue.size();
        doPush = v && (n != DEPTH) && !fl;
        doPop  = (n != 0) && rdy && !fl;
        if (rs || fl) begin
            sbQueue.delete();
        end else begin
            if (doPop) void'(sbQueue.pop_front());
            if (doPush) sbQueue.push_back({pc, in_inst});
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] single push, latency one");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] fill, hold while full, pop then accept");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
        end
        repeat (2) applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        repeat (DEPTH + 1) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] streaming wrap");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] flush with three entries");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during push and pop");
        applyStimulus(1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h94, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h98, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
